store_merge: RTL and testbench

STORE_MERGE -- requirements
Module: store_merge

---
 rtl/store_merge_pkg.sv | 45 ++++
 rtl/store_lane_merge.sv | 47 ++++
 rtl/store_merge.sv | 221 ++++++++++++++++++++++
 tb/tb_store_merge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_merge_pkg.sv
// -----------------------------------------------------------------------------
// store_merge_pkg
// Shared encodings for the store_merge block: store modes, FSM states and the
// small helpers that decide alignment and replicate a source value across lanes.
// Imported by store_merge (top) and store_lane_merge (lane insertion).
// -----------------------------------------------------------------------------
package store_merge_pkg;

    typedef enum logic [1:0] {
        STORE_WORD = 2'b00,
        STORE_HALF = 2'b01,
        STORE_BYTE = 2'b10,
        STORE_RSVD = 2'b11
    } store_mode_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_e;

    // A request is rejected when its address is not naturally aligned to its
    // size, or when the mode encoding is reserved.
    function automatic logic is_misaligned(input store_mode_e mode, input logic [1:0] addr_lo);
        case (mode)
            STORE_WORD: return (addr_lo != 2'b00);
            STORE_HALF: return addr_lo[0];
            STORE_BYTE: return 1'b0;
            default:    return 1'b1;
        endcase
    endfunction

    // Copy the live part of the source into every lane it could occupy:
    // byte -> x4, half -> x2, word -> unchanged.
    function automatic logic [31:0] replicate_lanes(input logic [31:0] src, input store_mode_e mode);
        case (mode)
            STORE_BYTE: return {4{src[7:0]}};
            STORE_HALF: return {2{src[15:0]}};
            default:    return src;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// -----------------------------------------------------------------------------
// store_lane_merge
// Combinational lane insertion for sub-word stores (little-endian lanes).
//   i_old     : word currently in memory
//   i_src     : register source value (low byte/half used for sub-word stores)
//   i_addr_lo : byte address bits [1:0]
//   i_mode    : store mode
//   o_merged  : i_old with the selected lane(s) replaced by the source
//   o_be      : byte enables of the lane(s) written
// -----------------------------------------------------------------------------
module store_lane_merge
    import store_merge_pkg::*;
(
    input  logic [31:0]  i_old,
    input  logic [31:0]  i_src,
    input  logic [1:0]   i_addr_lo,
    input  store_mode_e  i_mode,
    output logic [31:0]  o_merged,
    output logic [3:0]   o_be
);

    logic [31:0] w_rep;

    assign w_rep = replicate_lanes(i_src, i_mode);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path can
        // leave it unassigned, which would infer a latch.
        o_merged = i_old;
        o_be     = 4'b0000;

        case (i_mode)
            STORE_BYTE: o_be = 4'b0001 << i_addr_lo;
            STORE_HALF: o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    o_be = 4'b1111;
        endcase

        // The replicated source already has the right value in every lane, so
        // the enables alone pick which lanes come from it.
        for (int k = 0; k < 4; k++) begin
            if (o_be[k]) begin
                o_merged[8*k +: 8] = w_rep[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
// Turns byte/half/word store requests into whole-word memory writes.
// Default build: sub-word stores do read-modify-write (IDLE->RD->MRG->WR).
// With macro STORE_MERGE_BE_EN defined: a mem_be output is added and every
// aligned store goes IDLE->WR directly with replicated lanes and byte enables.
// Misaligned or reserved-mode requests go IDLE->ERR and pulse align_err.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_addr/wdata/mode   store byte address, source value, 00 W / 01 H / 10 B
//   mem_addr              word-aligned address, valid in RD/MRG/WR
//   mem_rd / mem_rdata    read strobe; data returned one cycle later
//   mem_we / mem_wdata    write strobe and data
//   mem_be                byte enables (STORE_MERGE_BE_EN only)
//   done / align_err      one-cycle completion / rejection pulses
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module store_merge
    import store_merge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
`ifdef STORE_MERGE_BE_EN
    output logic [3:0]        mem_be,
`endif
    output logic              done,
    output logic              align_err
);

    state_e              r_state;
    logic                r_req_ready;
    logic                r_mem_rd;
    logic                r_mem_we;
    logic                r_done;
    logic                r_align_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;

    store_mode_e         w_req_mode;
    logic                w_accept;
    logic                w_misaligned;
    logic [ADDR_W-1:0]   w_word_addr;

    logic [31:0]         w_old;
    logic [31:0]         w_src;
    logic [1:0]          w_lo;
    store_mode_e         w_mode;
    logic [31:0]         w_merged;
    logic [3:0]          w_be;

    assign w_req_mode   = store_mode_e'(req_mode);
    assign w_accept     = (r_state == IDLE) && r_req_ready && req_valid;
    assign w_misaligned = is_misaligned(w_req_mode, req_addr[1:0]);
    assign w_word_addr  = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_MERGE_BE_EN
    logic [3:0] r_mem_be;

    // Merge straight from the incoming request; with the old word also set to
    // the replicated source, every lane carries the source value.
    assign w_old  = replicate_lanes(req_wdata, w_req_mode);
    assign w_src  = req_wdata;
    assign w_lo   = req_addr[1:0];
    assign w_mode = w_req_mode;
`else
    logic [31:0] r_wdata;
    logic [1:0]  r_addr_lo;
    store_mode_e r_mode;

    // Merge in MRG, when the word read in RD is on mem_rdata.
    assign w_old  = mem_rdata;
    assign w_src  = r_wdata;
    assign w_lo   = r_addr_lo;
    assign w_mode = r_mode;
`endif

    store_lane_merge u_lane_merge (
        .i_old     (w_old),
        .i_src     (w_src),
        .i_addr_lo (w_lo),
        .i_mode    (w_mode),
        .o_merged  (w_merged),
        .o_be      (w_be)
    );

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef STORE_MERGE_BE_EN
            r_mem_be    <= 4'b0000;
`else
            r_wdata     <= '0;
            r_addr_lo   <= 2'b00;
            r_mode      <= STORE_WORD;
`endif
        end else begin
            // Strobes are single-cycle unless a branch below raises them.
            r_mem_rd    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_done      <= 1'b0;
            r_align_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
`ifndef STORE_MERGE_BE_EN
                        r_wdata     <= req_wdata;
                        r_addr_lo   <= req_addr[1:0];
                        r_mode      <= w_req_mode;
`endif
                        if (w_misaligned) begin
                            r_state     <= ERR;
                            r_align_err <= 1'b1;
`ifdef STORE_MERGE_BE_EN
                        end else begin
                            r_state     <= WR;
                            r_mem_we    <= 1'b1;
                            r_done      <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                            r_mem_wdata <= w_merged;
                            r_mem_be    <= w_be;
                        end
`else
                        end else if (w_req_mode == STORE_WORD) begin
                            r_state     <= WR;
                            r_mem_we    <= 1'b1;
                            r_done      <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                            r_mem_wdata <= req_wdata;
                        end else begin
                            r_state     <= RD;
                            r_mem_rd    <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                        end
`endif
                    end else begin
                        // Ready rises one edge after reset release and stays
                        // up while idle.
                        r_req_ready <= 1'b1;
                    end
                end

                RD: begin
                    r_state <= MRG;
                end

                MRG: begin
                    r_state     <= WR;
                    r_mem_we    <= 1'b1;
                    r_done      <= 1'b1;
                    r_mem_wdata <= w_merged;
                end

                WR: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
`ifdef STORE_MERGE_BE_EN
                    r_mem_be    <= 4'b0000;
`endif
                end

                ERR: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end

                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

`ifndef STORE_MERGE_BE_EN
    // Only half/byte stores reach MRG, and those always enable some lane.
    a_mrg_has_lane: assert property (@(posedge clk) disable iff (!reset_n)
        (r_state == MRG) |-> (w_be != 4'b0000));
`endif

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(r_mem_rd && r_mem_we) && !(r_align_err && (r_mem_rd || r_mem_we || r_done)));

    assign req_ready = r_req_ready;
    assign mem_rd    = r_mem_rd;
    assign mem_we    = r_mem_we;
    assign done      = r_done;
    assign align_err = r_align_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
`ifdef STORE_MERGE_BE_EN
    assign mem_be    = r_mem_be;
`endif

endmodule

// File: tb/tb_store_merge.sv
// -----------------------------------------------------------------------------
// tb_store_merge
// Directed bench for store_merge. Inputs are driven and outputs sampled on the
// falling clock edge; "+n" below means the n-th falling edge after the rising
// edge that accepts a request. flags = {req_ready, mem_rd, mem_we, done, align_err}.
// Build with +define+STORE_MERGE_BE_EN to exercise the byte-enable variant.
// -----------------------------------------------------------------------------
module tb_store_merge;

    localparam logic [1:0] M_WORD = 2'b00;
    localparam logic [1:0] M_HALF = 2'b01;
    localparam logic [1:0] M_BYTE = 2'b10;
    localparam logic [1:0] M_RSVD = 2'b11;
    localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_mode;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
`ifdef STORE_MERGE_BE_EN
    logic [3:0]  mem_be;
`endif
    logic        done;
    logic        align_err;

    logic [4:0]  flags;
    assign flags = {req_ready, mem_rd, mem_we, done, align_err};

    int n_total = 0;
    int n_pass  = 0;
    int cnt_rd  = 0;
    int cnt_we  = 0;
    int cnt_done = 0;

    store_merge #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mode  (req_mode),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
`ifdef STORE_MERGE_BE_EN
        .mem_be    (mem_be),
`endif
        .done      (done),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters, sampled just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (mem_rd) cnt_rd++;
        if (mem_we) cnt_we++;
        if (done)   cnt_done++;
    end

    // Present a request at a falling edge and drop it one cycle later.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        req_addr  = a;
        req_wdata = d;
        req_mode  = m;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mode  = M_WORD;
        mem_rdata = GARBAGE;
        repeat (2) @(negedge clk);
        n_total++;
        if (flags !== 5'b00000) $display("FAIL reset_flags: got %b want %b", flags, 5'b00000);
        else n_pass++;
        n_total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            $display("FAIL reset_mem: got addr %h wdata %h want 0 0", mem_addr, mem_wdata);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (flags !== 5'b10000) $display("FAIL reset_ready: got %b want %b", flags, 5'b10000);
        else n_pass++;
    endtask

    task automatic test_word();
        int rd0;
        rd0 = cnt_rd;
        send(32'h0000_0010, 32'hDEAD_BEEF, M_WORD);
        n_total++;
        if (flags !== 5'b00110) $display("FAIL word_flags: got %b want %b", flags, 5'b00110);
        else n_pass++;
        n_total++;
        if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF)
            $display("FAIL word_mem: got addr %h wdata %h want 00000010 deadbeef", mem_addr, mem_wdata);
        else n_pass++;
`ifdef STORE_MERGE_BE_EN
        n_total++;
        if (mem_be !== 4'b1111) $display("FAIL word_be: got %b want 1111", mem_be);
        else n_pass++;
`endif
        @(negedge clk);
        n_total++;
        if (flags !== 5'b10000 || mem_addr !== 32'h0)
            $display("FAIL word_idle: got %b addr %h want 10000 0", flags, mem_addr);
        else n_pass++;
        n_total++;
        if (cnt_rd - rd0 !== 0) $display("FAIL word_no_rd: got %0d reads want 0", cnt_rd - rd0);
        else n_pass++;
    endtask

`ifndef STORE_MERGE_BE_EN
    // One read-modify-write store with full cycle-by-cycle checks.
    task automatic rmw(input string name, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] m, input logic [31:0] rdata, input logic [31:0] exp);
        logic [31:0] wa;
        int we0;
        wa  = {a[31:2], 2'b00};
        we0 = cnt_we;
        mem_rdata = GARBAGE;
        send(a, d, m);
        n_total++;
        if (flags !== 5'b01000 || mem_addr !== wa)
            $display("FAIL %s_rd: got %b addr %h want 01000 %h", name, flags, mem_addr, wa);
        else n_pass++;
        @(negedge clk);
        mem_rdata = rdata;
        n_total++;
        if (flags !== 5'b00000 || mem_addr !== wa)
            $display("FAIL %s_mrg: got %b addr %h want 00000 %h", name, flags, mem_addr, wa);
        else n_pass++;
        @(negedge clk);
        mem_rdata = GARBAGE;
        n_total++;
        if (flags !== 5'b00110 || mem_addr !== wa || mem_wdata !== exp)
            $display("FAIL %s_wr: got %b addr %h wdata %h want 00110 %h %h",
                     name, flags, mem_addr, mem_wdata, wa, exp);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (flags !== 5'b10000 || cnt_we - we0 !== 1)
            $display("FAIL %s_end: got %b writes %0d want 10000 1", name, flags, cnt_we - we0);
        else n_pass++;
    endtask

    task automatic test_subword();
        rmw("byte3", 32'h0000_0013, 32'h0000_00AB, M_BYTE, 32'h1122_3344, 32'hAB22_3344);
        rmw("half1", 32'h0000_0022, 32'h1234_CAFE, M_HALF, 32'h5566_7788, 32'hCAFE_7788);
        rmw("half0", 32'h0000_0020, 32'h0000_BEEF, M_HALF, 32'h5566_7788, 32'h5566_BEEF);
        rmw("byte1", 32'h0000_0015, 32'hFFFF_FF5A, M_BYTE, 32'hAABB_CCDD, 32'hAABB_5ADD);
        rmw("byte2", 32'h0000_0006, 32'h0000_0001, M_BYTE, 32'h0000_0000, 32'h0001_0000);
    endtask
`endif

    task automatic test_misaligned();
        logic [31:0] addrs [3];
        logic [1:0]  modes [3];
        int rd0, we0;
        addrs = '{32'h0000_0021, 32'h0000_0012, 32'h0000_0000};
        modes = '{M_HALF, M_WORD, M_RSVD};
        for (int i = 0; i < 3; i++) begin
            rd0 = cnt_rd;
            we0 = cnt_we;
            send(addrs[i], 32'h1234_5678, modes[i]);
            n_total++;
            if (flags !== 5'b00001 || mem_addr !== 32'h0)
                $display("FAIL misalign%0d_err: got %b addr %h want 00001 0", i, flags, mem_addr);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (flags !== 5'b10000 || cnt_rd - rd0 !== 0 || cnt_we - we0 !== 0)
                $display("FAIL misalign%0d_end: got %b rd %0d we %0d want 10000 0 0",
                         i, flags, cnt_rd - rd0, cnt_we - we0);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int we0;
        we0 = cnt_we;
        send(32'h0000_0040, 32'h4040_4040, M_WORD);
        // Request held high through WR must wait for the IDLE cycle.
        req_addr  = 32'h0000_0044;
        req_wdata = 32'h4444_4444;
        req_mode  = M_WORD;
        req_valid = 1'b1;
        n_total++;
        if (flags !== 5'b00110 || mem_addr !== 32'h40)
            $display("FAIL b2b_first: got %b addr %h want 00110 40", flags, mem_addr);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (flags !== 5'b10000) $display("FAIL b2b_gap: got %b want 10000", flags);
        else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        n_total++;
        if (flags !== 5'b00110 || mem_addr !== 32'h44 || mem_wdata !== 32'h4444_4444)
            $display("FAIL b2b_second: got %b addr %h wdata %h want 00110 44 44444444",
                     flags, mem_addr, mem_wdata);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (flags !== 5'b10000 || cnt_we - we0 !== 2)
            $display("FAIL b2b_end: got %b writes %0d want 10000 2", flags, cnt_we - we0);
        else n_pass++;
    endtask

`ifndef STORE_MERGE_BE_EN
    task automatic test_reset_mid();
        int we0, dn0;
        we0 = cnt_we;
        dn0 = cnt_done;
        mem_rdata = GARBAGE;
        send(32'h0000_0013, 32'h0000_00AB, M_BYTE);
        @(negedge clk);
        mem_rdata = 32'h1122_3344;
        reset_n   = 1'b0;
        #1;
        n_total++;
        if (flags !== 5'b00000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            $display("FAIL rstmid_now: got %b addr %h wdata %h want 00000 0 0", flags, mem_addr, mem_wdata);
        else n_pass++;
        @(negedge clk);
        reset_n   = 1'b1;
        mem_rdata = GARBAGE;
        @(negedge clk);
        n_total++;
        if (flags !== 5'b10000 || cnt_we - we0 !== 0 || cnt_done - dn0 !== 0)
            $display("FAIL rstmid_abandon: got %b we %0d done %0d want 10000 0 0",
                     flags, cnt_we - we0, cnt_done - dn0);
        else n_pass++;
        send(32'h0000_0080, 32'h0BAD_F00D, M_WORD);
        n_total++;
        if (flags !== 5'b00110 || mem_addr !== 32'h80 || mem_wdata !== 32'h0BAD_F00D)
            $display("FAIL rstmid_next: got %b addr %h wdata %h want 00110 80 0badf00d",
                     flags, mem_addr, mem_wdata);
        else n_pass++;
        @(negedge clk);
    endtask
`else
    task automatic test_be();
        send(32'h0000_0011, 32'h0000_007F, M_BYTE);
        n_total++;
        if (flags !== 5'b00110 || mem_addr !== 32'h10 || mem_wdata !== 32'h7F7F_7F7F || mem_be !== 4'b0010)
            $display("FAIL be_byte: got %b addr %h wdata %h be %b want 00110 10 7f7f7f7f 0010",
                     flags, mem_addr, mem_wdata, mem_be);
        else n_pass++;
        @(negedge clk);
        send(32'h0000_0022, 32'h1234_CAFE, M_HALF);
        n_total++;
        if (flags !== 5'b00110 || mem_addr !== 32'h20 || mem_wdata !== 32'hCAFE_CAFE || mem_be !== 4'b1100)
            $display("FAIL be_half: got %b addr %h wdata %h be %b want 00110 20 cafecafe 1100",
                     flags, mem_addr, mem_wdata, mem_be);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (flags !== 5'b10000) $display("FAIL be_end: got %b want 10000", flags);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_word();
`ifndef STORE_MERGE_BE_EN
        test_subword();
`else
        test_be();
`endif
        test_misaligned();
        test_back_to_back();
`ifndef STORE_MERGE_BE_EN
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
